imm_ext_pipe: RTL and testbench
===============================

# imm_ext_pipe

Parametrised, pipelined immediate-extension unit for the multi-cycle/pipelined successor of the MIPS-32 datapath. It accepts an IN_W-bit immediate plus a 2-bit mode, and produces an OUT_W-bit operand through a valid/ready handshake. Modes are zero-extend, sign-extend, upper-load and sign-extend-shift-left-2. A two-entry skid buffer gives full throughput with a registered `in_ready`. It sits between the decode stage and the ALU-operand/branch-target muxes.

## Interface
- `IN_W`, 16, immediate width; legal range 2 to OUT_W-2.
- `OUT_W`, 32, result width.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  producer has an immediate.
- `in_ready`  out  1  unit can accept; registered.
- `in_data`  in  IN_W  raw immediate.
- `in_mode`  in  2  0=ZERO, 1=SIGN, 2=UPPER, 3=SHL2.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  consumer accepts.
- `out_data`  out  OUT_W  extended result.
- `out_neg`  out  1  MSB of `out_data`.
- `out_mode`  out  2  mode that produced `out_data`.

## Operation
- Transfer in: `in_valid & in_ready` at a rising edge. Transfer out: `out_valid & out_ready` at a rising edge.
- Extension is combinational on the input side and is computed before storage. Modes:
  - ZERO: `{(OUT_W-IN_W){0}, in_data}`.
  - SIGN: `{(OUT_W-IN_W){in_data[IN_W-1]}, in_data}`.
  - UPPER: `in_data << (OUT_W-IN_W)`, with the low bits zero.
  - SHL2: sign-extend, then shift left by 2. The top 2 bits are discarded; no overflow is possible given the IN_W limit.
- Storage is an output register (MAIN) plus one skid register (SKID), tracked by occupancy `occ` ∈ {0,1,2}.
- `occ` transitions:
  - 0 to 1 on push.
  - 1 to 2 on push without pop.
  - 1 to 0 on pop without push.
  - 1 stays 1 on push and pop together; the new value loads MAIN.
  - 2 to 1 on pop; SKID moves to MAIN.
- At `occ=2`, `in_ready=0`, so no push can occur.
- `out_valid = (occ != 0)`. `out_data`, `out_neg` and `out_mode` always reflect MAIN.
- `in_ready` is registered: next value is `!(next_occ == 2)`.
- Order is strict FIFO; no entry is dropped or duplicated.
- `in_data` and `in_mode` are ignored when no transfer occurs.
- While `out_valid=1 & out_ready=0`, `out_data`, `out_neg` and `out_mode` hold stable.

## Timing
- Reset (async assert, synchronous deassert at the boundary): `occ=0`, `out_valid=0`, `out_data=0`, `out_neg=0`, `out_mode=0`, `in_ready=1` in the first cycle after deassert.
- Latency is 1 cycle: data pushed at edge N is on `out_data` with `out_valid=1` after edge N.
- Throughput is 1 transfer/cycle sustained when `out_ready=1`.
- After `out_ready` drops, 2 further pushes are absorbed. `in_ready` falls at the edge that fills SKID and rises at the edge after the first pop.
- Reset mid-operation discards both entries immediately; outputs return to reset values without waiting for a clock.
- Push while empty and pop in the same cycle: impossible, since `out_valid=0` at `occ=0`.

## Structure
- Package `imm_ext_pkg`: mode localparams `MODE_ZERO`, `MODE_SIGN`, `MODE_UPPER`, `MODE_SHL2`, and a width-parametrised extend function shared with the single-cycle `signExtension` replacement.
- Sub-module `imm_skid_buf` is a generic 2-entry valid/ready skid buffer with parameter `W`. `imm_ext_pipe` instantiates it with `W=OUT_W+2` (data + mode) and derives `out_neg`.

## Test plan
- SIGN, `in_data=16'hFFE5` (-27) -> `out_data=32'hFFFFFFE5`, `out_neg=1`, one cycle after the push.
- ZERO, `16'hFFE5` -> `32'h0000FFE5`, `out_neg=0`; UPPER, `16'h03E7` (999) -> `32'h03E70000`.
- SHL2, `16'hFCEE` (-786) -> `32'hFFFFF3B8`; SHL2, `16'h002C` (44) -> `32'h000000B0`.
- Backpressure:
  - Stimulus: hold `out_ready=0` and push 3 values back-to-back.
  - Required: 2 are accepted and `in_ready=0` from the 3rd cycle.
  - Stimulus: release `out_ready`.
  - Required: outputs appear in order with no loss; `in_ready` returns to 1 one cycle after the first pop.
- Streaming: `out_ready=1`, 100 random pushes -> 100 pops in order, 1 per cycle, each matching the reference model.
- Reset: assert `rst_n=0` mid-cycle with `occ=2` -> `out_valid=0` and `out_data=0` asynchronously, and `in_ready=1` after deassert.

Source files
------------

// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate-extension pipeline: mode encodings,
// skid occupancy states and a width-generic extend function.
package imm_ext_pkg;

  localparam logic [1:0] MODE_ZERO  = 2'd0;
  localparam logic [1:0] MODE_SIGN  = 2'd1;
  localparam logic [1:0] MODE_UPPER = 2'd2;
  localparam logic [1:0] MODE_SHL2  = 2'd3;

  localparam int EXT_MAX_W = 64;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  // Widths are arguments so the single-cycle datapath can reuse this with its
  // own sizes; callers pass constants, so the masks and shifts fold away.
  function automatic logic [EXT_MAX_W-1:0] imm_extend(
    input logic [EXT_MAX_W-1:0] data,
    input logic [1:0]           mode,
    input int                   in_w,
    input int                   out_w
  );
    logic [EXT_MAX_W-1:0] in_mask;
    logic [EXT_MAX_W-1:0] out_mask;
    logic [EXT_MAX_W-1:0] zext;
    logic [EXT_MAX_W-1:0] sext;
    logic [EXT_MAX_W-1:0] res;
    in_mask  = {EXT_MAX_W{1'b1}} >> (EXT_MAX_W - in_w);
    out_mask = {EXT_MAX_W{1'b1}} >> (EXT_MAX_W - out_w);
    zext     = data & in_mask;
    sext     = ((zext & ~(in_mask >> 1)) != '0) ? (zext | ~in_mask) : zext;
    res      = '0;
    case (mode)
      MODE_ZERO:  res = zext;
      MODE_SIGN:  res = sext;
      MODE_UPPER: res = zext << (out_w - in_w);
      MODE_SHL2:  res = sext << 2;
      default:    res = '0;
    endcase
    return res & out_mask;
  endfunction

endpackage

// File: rtl/imm_skid_buf.sv
// Generic two-entry valid/ready skid buffer with a registered in_ready.
//   state     | meaning
//   OCC_EMPTY | no entry held, out_valid low
//   OCC_ONE   | MAIN holds the head entry
//   OCC_TWO   | MAIN holds the head, SKID holds the next entry; input stalled
module imm_skid_buf #(
  parameter int W = 34
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  import imm_ext_pkg::*;

  occ_e         state;
  occ_e         state_nxt;
  logic [W-1:0] main_q;
  logic [W-1:0] skid_q;
  logic         ready_q;
  logic         push;
  logic         pop;
  logic         load_main;
  logic         load_skid;
  logic         skid_to_main;

  assign push      = in_valid & ready_q;
  assign pop       = out_valid & out_ready;
  assign out_valid = (state != OCC_EMPTY);
  assign out_data  = main_q;
  assign in_ready  = ready_q;

  always_comb begin
    state_nxt    = state;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    case (state)
      OCC_EMPTY: begin
        if (push) begin
          state_nxt = OCC_ONE;
          load_main = 1'b1;
        end
      end
      OCC_ONE: begin
        if (push && pop) begin
          load_main = 1'b1;
        end else if (push) begin
          state_nxt = OCC_TWO;
          load_skid = 1'b1;
        end else if (pop) begin
          state_nxt = OCC_EMPTY;
        end
      end
      OCC_TWO: begin
        if (pop) begin
          state_nxt    = OCC_ONE;
          skid_to_main = 1'b1;
        end
      end
      default: state_nxt = OCC_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= OCC_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      state   <= state_nxt;
      ready_q <= (state_nxt != OCC_TWO);
      if (load_main) begin
        main_q <= in_data;
      end else if (skid_to_main) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_data;
      end
    end
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// Pipelined immediate extension between decode and the ALU-operand/branch
// muxes: extend on the input side, then hold result and mode in a skid buffer.
module imm_ext_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_neg,
  output logic [1:0]       out_mode
);
  import imm_ext_pkg::*;

  logic [EXT_MAX_W-1:0] raw;
  logic [EXT_MAX_W-1:0] ext_full;
  logic [OUT_W+1:0]     main_word;
  logic                 unused_ext_hi;

  assign raw           = {{(EXT_MAX_W-IN_W){1'b0}}, in_data};
  assign ext_full      = imm_extend(raw, in_mode, IN_W, OUT_W);
  // The function masks to OUT_W, so the upper bits are always zero.
  assign unused_ext_hi = &{1'b0, ext_full[EXT_MAX_W-1:OUT_W]};

  imm_skid_buf #(
    .W(OUT_W+2)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({in_mode, ext_full[OUT_W-1:0]}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (main_word)
  );

  assign out_data = main_word[OUT_W-1:0];
  assign out_mode = main_word[OUT_W+1:OUT_W];
  assign out_neg  = main_word[OUT_W-1];

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Scoreboard bench for imm_ext_pipe: directed vectors, backpressure,
// streaming, random backpressure and mid-operation reset.
module tb_imm_ext_pipe;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  mode;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_neg;
  logic [1:0]  out_mode;

  int   tests = 0;
  int   fails = 0;
  int   pop_count = 0;
  int   send_cycles = 0;
  exp_t sb[$];

  logic        prev_stall = 1'b0;
  logic [34:0] prev_out;

  imm_ext_pipe #(.IN_W(16), .OUT_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_neg   (out_neg),
    .out_mode  (out_mode)
  );

  always #5 clk = ~clk;

  // Reference: MIPS immediate semantics as plain integer arithmetic.
  function automatic exp_t model(input logic [15:0] d, input logic [1:0] m);
    exp_t e;
    int   s;
    s = int'($signed(d));
    e.mode = m;
    case (m)
      2'd0:    e.data = 32'(d);
      2'd1:    e.data = s;
      2'd2:    e.data = 32'(d) * 32'd65536;
      default: e.data = s * 4;
    endcase
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: inputs change only just after posedge, so the negedge view
  // predicts exactly which transfers the next rising edge performs.
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall)
        check("hold", {out_valid, out_mode, out_data}, prev_out);
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_valid, out_mode, out_data};
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_underflow: got data %0h with no entry expected", out_data);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sb_data", 64'(out_data), 64'(e.data));
          check("sb_mode", 64'(out_mode), 64'(e.mode));
          check("sb_neg", 64'(out_neg), 64'(e.data[31]));
          pop_count++;
        end
      end
      if (in_valid && in_ready)
        sb.push_back(model(in_data, in_mode));
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [15:0] d, input logic [1:0] m, input bit rnd_ready);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    for (int i = 0; i < 64 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      send_cycles++;
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    end
    in_valid = 1'b0;
    if (!acc) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready got 0 expected 1 within 64 cycles");
    end
  endtask

  task automatic directed(input logic [15:0] d, input logic [1:0] m,
                          input logic [31:0] exp_data, input logic exp_neg);
    send(d, m, 1'b0);
    @(negedge clk);
    check("lat_valid", 64'(out_valid), 64'd1);
    check("dir_data", 64'(out_data), 64'(exp_data));
    check("dir_neg", 64'(out_neg), 64'(exp_neg));
    check("dir_mode", 64'(out_mode), 64'(m));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t e0;
    int   pc0;
    int   sc0;
    logic [15:0] v;

    rst_n = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_mode = '0;
    out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_neg", 64'(out_neg), 64'd0);
    check("rst_out_mode", 64'(out_mode), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_idle_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;

    out_ready = 1'b1;
    directed(16'hFFE5, 2'd1, 32'hFFFFFFE5, 1'b1);
    directed(16'hFFE5, 2'd0, 32'h0000FFE5, 1'b0);
    directed(16'h03E7, 2'd2, 32'h03E70000, 1'b0);
    directed(16'hFCEE, 2'd3, 32'hFFFFF3B8, 1'b1);
    directed(16'h002C, 2'd3, 32'h000000B0, 1'b0);

    // Backpressure: two pushes absorbed, third stalls until the first pop.
    out_ready = 1'b0;
    v = 16'($urandom);
    e0 = model(v, 2'd1);
    send(v, 2'd1, 1'b0);
    send(16'($urandom), 2'($urandom), 1'b0);
    in_valid = 1'b1;
    in_data  = 16'($urandom);
    in_mode  = 2'($urandom);
    @(negedge clk);
    check("bp_full_ready", 64'(in_ready), 64'd0);
    check("bp_head_data", 64'(out_data), 64'(e0.data));
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_still_full", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    check("bp_pre_pop_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_ready_rise", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("bp_drained", 64'(sb.size()), 64'd0);

    // Streaming at full rate.
    out_ready = 1'b1;
    pc0 = pop_count;
    sc0 = send_cycles;
    for (int i = 0; i < 100; i++)
      send(16'($urandom), 2'($urandom), 1'b0);
    check("stream_no_stall", 64'(send_cycles - sc0), 64'd100);
    @(negedge clk);
    @(posedge clk);
    #1;
    check("stream_pops", 64'(pop_count - pc0), 64'd100);

    // Random backpressure with idle cycles carrying junk data.
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        in_mode  = 2'($urandom);
        @(posedge clk);
        #1 out_ready = 1'($urandom_range(0, 1));
      end else begin
        send(16'($urandom), 2'($urandom), 1'b1);
      end
    end
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rand_drained", 64'(sb.size()), 64'd0);

    // Reset mid-operation with both entries full.
    out_ready = 1'b0;
    send(16'($urandom), 2'($urandom), 1'b0);
    send(16'($urandom), 2'($urandom), 1'b0);
    check("mid_full_ready", 64'(in_ready), 64'd0);
    #2 rst_n = 1'b0;
    sb.delete();
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_data", 64'(out_data), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_empty", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(16'h8001, 2'd1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("final_drain", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
